// File: rtl/uart_ram_arbiter.sv
// Arbitrates servant_ram between the CPU Wishbone master and a single-byte UART RX write-back buffer.
// Optional UART_ARB_WRAP_IRQ_EN adds o_wrap_irq, a one-cycle pulse after the RX pointer wraps.
module uart_ram_arbiter #(
    parameter logic [31:0] ADR_LL = 32'h00C00000,
    parameter logic [31:0] ADR_UL = 32'h00C10000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_cpu_adr,
    input  logic [31:0] i_cpu_dat,
    input  logic [3:0]  i_cpu_sel,
    input  logic        i_cpu_cyc,
    input  logic        i_cpu_we,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    input  logic        i_rx_done,
    input  logic [7:0]  i_rx_dat,
    output logic [31:0] o_ram_adr,
    output logic [31:0] o_ram_dat,
    output logic [3:0]  o_ram_sel,
    output logic        o_ram_cyc,
    output logic        o_ram_we,
    input  logic [31:0] i_ram_rdt,
    input  logic        i_ram_ack,
    output logic [31:0] o_wr_ptr,
`ifdef UART_ARB_WRAP_IRQ_EN
    output logic        o_wrap_irq,
`endif
    output logic        o_rx_overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_RX   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pending;
    logic [7:0]  r_byte;
    logic [31:0] r_wr_ptr;
    logic        r_last_rx;
    logic        r_overrun;
    logic        w_rx_ack;
    logic        w_wrap;
    logic [31:0] w_ptr_nxt;

    assign w_rx_ack  = (r_state == S_RX) && i_ram_ack;
    assign w_wrap    = w_rx_ack && (r_wr_ptr == ADR_UL);
    assign w_ptr_nxt = (r_wr_ptr == ADR_UL) ? ADR_LL : r_wr_ptr + 32'd1;

    assign o_wr_ptr     = r_wr_ptr;
    assign o_rx_overrun = r_overrun;
    assign o_cpu_rdt    = i_ram_rdt;

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_byte    <= '0;
            r_wr_ptr  <= ADR_LL;
            r_last_rx <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= 1'b0;
            if (r_state == S_IDLE && w_state_nxt == S_CPU)
                r_last_rx <= 1'b0;
            else if (r_state == S_IDLE && w_state_nxt == S_RX)
                r_last_rx <= 1'b1;
            // A byte arriving on the same cycle its predecessor is acked refills the buffer
            if (i_rx_done && (!r_pending || w_rx_ack)) begin
                r_byte    <= i_rx_dat;
                r_pending <= 1'b1;
            end else begin
                if (i_rx_done)
                    r_overrun <= 1'b1;
                if (w_rx_ack)
                    r_pending <= 1'b0;
            end
            if (w_rx_ack)
                r_wr_ptr <= w_ptr_nxt;
        end
    end

`ifdef UART_ARB_WRAP_IRQ_EN
    logic r_wrap_irq;
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst)
            r_wrap_irq <= 1'b0;
        else
            r_wrap_irq <= w_wrap;
    end
    assign o_wrap_irq = r_wrap_irq;
`else
    logic w_wrap_unused;
    assign w_wrap_unused = w_wrap;
`endif

    always_comb begin
        w_state_nxt = r_state;
        o_ram_adr   = '0;
        o_ram_dat   = '0;
        o_ram_sel   = '0;
        o_ram_cyc   = 1'b0;
        o_ram_we    = 1'b0;
        o_cpu_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_cyc && r_pending)
                    w_state_nxt = r_last_rx ? S_CPU : S_RX;
                else if (i_cpu_cyc)
                    w_state_nxt = S_CPU;
                else if (r_pending)
                    w_state_nxt = S_RX;
            end
            S_CPU: begin
                o_ram_adr = i_cpu_adr;
                o_ram_dat = i_cpu_dat;
                o_ram_sel = i_cpu_sel;
                o_ram_we  = i_cpu_we;
                o_ram_cyc = 1'b1;
                o_cpu_ack = i_ram_ack;
                if (i_ram_ack)
                    w_state_nxt = S_IDLE;
            end
            S_RX: begin
                o_ram_adr = r_wr_ptr;
                o_ram_dat = {4{r_byte}};
                o_ram_sel = 4'b0001 << r_wr_ptr[1:0];
                o_ram_we  = 1'b1;
                o_ram_cyc = 1'b1;
                if (i_ram_ack)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Directed bench for uart_ram_arbiter, built with ADR_UL = ADR_LL + 3 so the pointer wrap is reachable.
module tb_uart_ram_arbiter;

    localparam logic [31:0] LL = 32'h00C00000;
    localparam logic [31:0] UL = 32'h00C00003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_dat = '0;
    logic [3:0]  cpu_sel = '0;
    logic        cpu_cyc = 1'b0;
    logic        cpu_we  = 1'b0;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_dat  = '0;
    logic [31:0] ram_adr;
    logic [31:0] ram_dat;
    logic [3:0]  ram_sel;
    logic        ram_cyc;
    logic        ram_we;
    logic [31:0] ram_rdt = '0;
    logic        ram_ack = 1'b0;
    logic [31:0] wr_ptr;
    logic        rx_overrun;
`ifdef UART_ARB_WRAP_IRQ_EN
    logic        wrap_irq;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    uart_ram_arbiter #(.ADR_LL(LL), .ADR_UL(UL)) dut (
        .i_wb_clk    (clk),
        .i_wb_rst    (rst),
        .i_cpu_adr   (cpu_adr),
        .i_cpu_dat   (cpu_dat),
        .i_cpu_sel   (cpu_sel),
        .i_cpu_cyc   (cpu_cyc),
        .i_cpu_we    (cpu_we),
        .o_cpu_rdt   (cpu_rdt),
        .o_cpu_ack   (cpu_ack),
        .i_rx_done   (rx_done),
        .i_rx_dat    (rx_dat),
        .o_ram_adr   (ram_adr),
        .o_ram_dat   (ram_dat),
        .o_ram_sel   (ram_sel),
        .o_ram_cyc   (ram_cyc),
        .o_ram_we    (ram_we),
        .i_ram_rdt   (ram_rdt),
        .i_ram_ack   (ram_ack),
        .o_wr_ptr    (wr_ptr),
`ifdef UART_ARB_WRAP_IRQ_EN
        .o_wrap_irq  (wrap_irq),
`endif
        .o_rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        settle();
        check("rst_cyc", {31'd0, ram_cyc}, 32'd0);
        check("rst_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_ptr", wr_ptr, LL);
        check("rst_ovr", {31'd0, rx_overrun}, 32'd0);

        // single RX byte
        rx_done = 1'b1; rx_dat = 8'hA5;
        step();
        rx_done = 1'b0; settle();
        check("rx1_idle_cyc", {31'd0, ram_cyc}, 32'd0);
        step();
        check("rx1_cyc", {31'd0, ram_cyc}, 32'd1);
        check("rx1_we",  {31'd0, ram_we}, 32'd1);
        check("rx1_adr", ram_adr, 32'h00C00000);
        check("rx1_sel", {28'd0, ram_sel}, 32'h1);
        check("rx1_dat", ram_dat, 32'hA5A5A5A5);
        ram_ack = 1'b1; settle();
        check("rx1_noack_cpu", {31'd0, cpu_ack}, 32'd0);
        step();
        ram_ack = 1'b0; settle();
        check("rx1_done_cyc", {31'd0, ram_cyc}, 32'd0);
        check("rx1_ptr", wr_ptr, 32'h00C00001);

        // CPU read
        cpu_cyc = 1'b1; cpu_adr = 32'h00000010; cpu_we = 1'b0; cpu_sel = 4'hF;
        ram_rdt = 32'h12345678; settle();
        check("cpu_idle_cyc", {31'd0, ram_cyc}, 32'd0);
        check("cpu_idle_rdt", cpu_rdt, 32'h12345678);
        step();
        check("cpu_cyc", {31'd0, ram_cyc}, 32'd1);
        check("cpu_adr", ram_adr, 32'h00000010);
        check("cpu_we",  {31'd0, ram_we}, 32'd0);
        check("cpu_sel", {28'd0, ram_sel}, 32'hF);
        check("cpu_ack_lo", {31'd0, cpu_ack}, 32'd0);
        ram_ack = 1'b1; ram_rdt = 32'hDEADBEEF; settle();
        check("cpu_ack_hi", {31'd0, cpu_ack}, 32'd1);
        check("cpu_rdt", cpu_rdt, 32'hDEADBEEF);
        step();
        ram_ack = 1'b0; cpu_cyc = 1'b0; settle();
        check("cpu_done_cyc", {31'd0, ram_cyc}, 32'd0);
        check("cpu_done_ack", {31'd0, cpu_ack}, 32'd0);

        // round-robin ties after a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        rx_done = 1'b1; rx_dat = 8'h3C;
        step();
        rx_done = 1'b0;
        cpu_cyc = 1'b1; cpu_adr = 32'h00000020; cpu_we = 1'b1; cpu_dat = 32'h11223344;
        step();
        check("tie1_cyc", {31'd0, ram_cyc}, 32'd1);
        check("tie1_adr_cpu", ram_adr, 32'h00000020);
        check("tie1_dat_cpu", ram_dat, 32'h11223344);
        ram_ack = 1'b1; step();
        ram_ack = 1'b0; settle();
        check("tie1_gap_cyc", {31'd0, ram_cyc}, 32'd0);
        step();
        check("tie2_adr_rx", ram_adr, 32'h00C00000);
        check("tie2_dat_rx", ram_dat, 32'h3C3C3C3C);
        check("tie2_sel_rx", {28'd0, ram_sel}, 32'h1);
        ram_ack = 1'b1; rx_done = 1'b1; rx_dat = 8'h5A;
        step();
        ram_ack = 1'b0; rx_done = 1'b0; settle();
        check("refill_ovr", {31'd0, rx_overrun}, 32'd0);
        check("refill_ptr", wr_ptr, 32'h00C00001);
        step();
        check("tie3_adr_cpu", ram_adr, 32'h00000020);
        ram_ack = 1'b1; step();
        ram_ack = 1'b0; cpu_cyc = 1'b0; cpu_we = 1'b0;
        step();
        check("refill_adr", ram_adr, 32'h00C00001);
        check("refill_sel", {28'd0, ram_sel}, 32'h2);
        check("refill_dat", ram_dat, 32'h5A5A5A5A);
        ram_ack = 1'b1; step();
        ram_ack = 1'b0; settle();
        check("refill_ptr2", wr_ptr, 32'h00C00002);

        // overrun while CPU stalls the bus
        cpu_cyc = 1'b1; cpu_adr = 32'h00000030;
        step();
        rx_done = 1'b1; rx_dat = 8'h77;
        step();
        rx_done = 1'b0; settle();
        check("ovr_first_lo", {31'd0, rx_overrun}, 32'd0);
        step();
        rx_done = 1'b1; rx_dat = 8'h88;
        step();
        rx_done = 1'b0; settle();
        check("ovr_pulse", {31'd0, rx_overrun}, 32'd1);
        step();
        check("ovr_once", {31'd0, rx_overrun}, 32'd0);
        ram_ack = 1'b1; step();
        ram_ack = 1'b0; cpu_cyc = 1'b0;
        step();
        check("ovr_dat_kept", ram_dat, 32'h77777777);
        check("ovr_adr", ram_adr, 32'h00C00002);
        check("ovr_sel", {28'd0, ram_sel}, 32'h4);
        ram_ack = 1'b1; step();
        ram_ack = 1'b0; settle();
        check("ovr_ptr", wr_ptr, 32'h00C00003);
        step();
        check("ovr_no_second", {31'd0, ram_cyc}, 32'd0);

        // pointer wrap at ADR_UL
        rx_done = 1'b1; rx_dat = 8'hE1;
        step();
        rx_done = 1'b0;
        step();
        check("wrap_adr", ram_adr, UL);
        check("wrap_sel", {28'd0, ram_sel}, 32'h8);
        ram_ack = 1'b1; step();
        ram_ack = 1'b0; settle();
        check("wrap_ptr", wr_ptr, LL);
`ifdef UART_ARB_WRAP_IRQ_EN
        check("wrap_irq_hi", {31'd0, wrap_irq}, 32'd1);
        step();
        check("wrap_irq_lo", {31'd0, wrap_irq}, 32'd0);
`endif

        // reset mid RX transfer
        rx_done = 1'b1; rx_dat = 8'h99;
        step();
        rx_done = 1'b0;
        step();
        check("rrx_cyc_pre", {31'd0, ram_cyc}, 32'd1);
        step();
        rst = 1'b1; step();
        rst = 1'b0; settle();
        check("rrx_cyc", {31'd0, ram_cyc}, 32'd0);
        check("rrx_ptr", wr_ptr, LL);
        step(); step();
        check("rrx_pending_gone", {31'd0, ram_cyc}, 32'd0);

        // reset mid CPU transfer: no ack leaks out
        cpu_cyc = 1'b1;
        step();
        check("rcpu_cyc_pre", {31'd0, ram_cyc}, 32'd1);
        rst = 1'b1; step();
        rst = 1'b0; ram_ack = 1'b1; settle();
        check("rcpu_cyc", {31'd0, ram_cyc}, 32'd0);
        check("rcpu_ack", {31'd0, cpu_ack}, 32'd0);
        ram_ack = 1'b0; cpu_cyc = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
